// File: rtl/mc_pkg.sv
// Shared types and constants for the missionaries-and-cannibals move checker.
package mc_pkg;

  localparam logic [1:0] MC_N    = 2'd3;
  localparam int         ENTRY_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE_S  = 2'd1,
    FAULT_S = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LOAD = 2'd1;
  localparam logic [1:0] ERR_BANK = 2'd2;
  localparam logic [1:0] ERR_FIN  = 2'd3;

  // True when missionaries are outnumbered on either bank; l/m count the start bank.
  function automatic logic bank_unsafe(input logic [1:0] l, input logic [1:0] m);
    logic [1:0] fl;
    logic [1:0] fm;
    fl = MC_N - l;
    fm = MC_N - m;
    return ((l != 2'd0) && (m > l)) || ((fl != 2'd0) && (fm > fl));
  endfunction

endpackage

// File: rtl/mc_trace_ram.sv
// Move trace store: register array with synchronous read, write enable and async clear.
module mc_trace_ram
  import mc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the array is reset because unwritten entries must read back as 0;
  // this keeps it in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (we) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/mc_move_checker.sv
// Rule checker for solver bank-state steps: counts legal moves, traces them, latches a verdict.
module mc_move_checker
  import mc_pkg::*;
#(
  parameter int TRACE_DEPTH = 16,
  parameter int MOVE_W      = 5,
  localparam int AW         = $clog2(TRACE_DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               VALID,
  input  logic [1:0]         L,
  input  logic [1:0]         M,
  input  logic               K,
  input  logic [AW-1:0]      RD_ADDR,
  output logic [ENTRY_W-1:0] RD_DATA,
  output logic [MOVE_W-1:0]  MOVES,
  output logic               DONE,
  output logic               FAULT,
  output logic [1:0]         ERR,
  output logic               FULL
);

  state_t            state;
  logic [1:0]        prev_m;
  logic [1:0]        prev_c;
  logic              side;
  logic [AW:0]       wr_ptr;
  logic signed [2:0] dm;
  logic signed [2:0] dc;
  logic signed [3:0] load;
  logic [1:0]        err_code;
  logic              accept;
  logic              we;

  // NOTE: every combinational output gets a default up front so no path leaves it
  // unassigned; that is what keeps this block from inferring a latch.
  always_comb begin
    dm       = '0;
    dc       = '0;
    err_code = ERR_NONE;
    if (!side) begin
      dm = $signed({1'b0, prev_m}) - $signed({1'b0, L});
      dc = $signed({1'b0, prev_c}) - $signed({1'b0, M});
    end else begin
      dm = $signed({1'b0, L}) - $signed({1'b0, prev_m});
      dc = $signed({1'b0, M}) - $signed({1'b0, prev_c});
    end
    load = {dm[2], dm} + {dc[2], dc};
    if (dm[2] || dc[2] || !((load == 4'sd1) || (load == 4'sd2)))
      err_code = ERR_LOAD;
    else if (bank_unsafe(L, M))
      err_code = ERR_BANK;
    else if (K != ((L == 2'd0) && (M == 2'd0)))
      err_code = ERR_FIN;
    accept = (state == RUN) && VALID && (err_code == ERR_NONE);
  end

  // wr_ptr parks at TRACE_DEPTH, so its top bit is the registered full flag.
  assign we   = accept && !wr_ptr[AW];
  assign FULL = wr_ptr[AW];

  mc_trace_ram #(
    .DEPTH (TRACE_DEPTH),
    .AW    (AW)
  ) u_trace (
    .CLK     (CLK),
    .RST     (RST),
    .we      (we),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({~side, L, M}),
    .rd_addr (RD_ADDR),
    .rd_data (RD_DATA)
  );

  // NOTE: all state here updates with non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= RUN;
      prev_m <= MC_N;
      prev_c <= MC_N;
      side   <= 1'b0;
      wr_ptr <= '0;
      MOVES  <= '0;
      DONE   <= 1'b0;
      FAULT  <= 1'b0;
      ERR    <= ERR_NONE;
    end else begin
      case (state)
        RUN: begin
          if (VALID) begin
            if (err_code != ERR_NONE) begin
              state <= FAULT_S;
              FAULT <= 1'b1;
              ERR   <= err_code;
            end else begin
              if (MOVES != '1) MOVES <= MOVES + 1'b1;
              if (!wr_ptr[AW]) wr_ptr <= wr_ptr + 1'b1;
              prev_m <= L;
              prev_c <= M;
              side   <= ~side;
              if (K) begin
                state <= DONE_S;
                DONE  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
